// File: rtl/snoop_mem_nexus.sv
// Shared line store for two snooping L1s: one-at-a-time reads with fixed latency, posted write-backs.
// Optional NEXUS_STATS_EN adds saturating read/eviction counters.
module snoop_mem_nexus #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned LINE_BITS = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    snooper_addr_a,
    input  logic [31:0]    snooper_addr_b,
    input  logic           snooper_read_valid_a,
    input  logic           snooper_read_valid_b,
    input  logic           eviction_wren_a,
    input  logic           eviction_wren_b,
    input  logic [127:0]   evictable_cacheline_a,
    input  logic [127:0]   evictable_cacheline_b,
    input  logic           l1_busy_a,
    input  logic           l1_busy_b,
    output logic [127:0]   updated_cacheline_a,
    output logic [127:0]   updated_cacheline_b,
    output logic           cacheline_update_valid_a,
    output logic           cacheline_update_valid_b
`ifdef NEXUS_STATS_EN
    ,
    output logic [15:0]    stat_reads,
    output logic [15:0]    stat_evictions
`endif
);

    localparam int unsigned Lines = 1 << LINE_BITS;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 grant_q, grant_d;
    logic [3:0]           count_q, count_d;
    logic                 pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic [LINE_BITS-1:0] pend_line_a_q, pend_line_a_d, pend_line_b_q, pend_line_b_d;
    logic                 resp_done;

    logic [LINE_BITS-1:0] line_a, line_b, grant_line;
    logic [127:0]         resp_data;
    logic                 grant_busy;

    // Contents survive reset; zero start only matters for simulation.
    logic [127:0] mem [Lines] = '{default: '0};

    assign line_a = snooper_addr_a[LINE_BITS+3:4];
    assign line_b = snooper_addr_b[LINE_BITS+3:4];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{snooper_addr_a[31:LINE_BITS+4], snooper_addr_a[3:0],
                                snooper_addr_b[31:LINE_BITS+4], snooper_addr_b[3:0]};

    assign grant_line = grant_q ? pend_line_b_q : pend_line_a_q;
    assign grant_busy = grant_q ? l1_busy_b : l1_busy_a;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        count_d   = count_q;
        resp_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pend_a_q) begin
                    grant_d = 1'b0;
                    count_d = 4'(LATENCY);
                    state_d = StWait;
                end else if (pend_b_q) begin
                    grant_d = 1'b1;
                    count_d = 4'(LATENCY);
                    state_d = StWait;
                end
            end
            StWait: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) state_d = StResp;
            end
            StResp: begin
                if (!grant_busy) begin
                    resp_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A new request on a port is only accepted once its previous one has been answered.
    always_comb begin
        pend_a_d      = pend_a_q;
        pend_b_d      = pend_b_q;
        pend_line_a_d = pend_line_a_q;
        pend_line_b_d = pend_line_b_q;
        if (resp_done && !grant_q) begin
            pend_a_d = 1'b0;
        end else if (!pend_a_q && snooper_read_valid_a) begin
            pend_a_d      = 1'b1;
            pend_line_a_d = line_a;
        end
        if (resp_done && grant_q) begin
            pend_b_d = 1'b0;
        end else if (!pend_b_q && snooper_read_valid_b) begin
            pend_b_d      = 1'b1;
            pend_line_b_d = line_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            grant_q       <= 1'b0;
            count_q       <= 4'd0;
            pend_a_q      <= 1'b0;
            pend_b_q      <= 1'b0;
            pend_line_a_q <= '0;
            pend_line_b_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            count_q       <= count_d;
            pend_a_q      <= pend_a_d;
            pend_b_q      <= pend_b_d;
            pend_line_a_q <= pend_line_a_d;
            pend_line_b_q <= pend_line_b_d;
        end
    end

    // Port a is written last so it wins a same-line collision.
    always_ff @(posedge clk) begin
        if (eviction_wren_b) mem[line_b] <= evictable_cacheline_b;
        if (eviction_wren_a) mem[line_a] <= evictable_cacheline_a;
    end

    always_comb begin
        if (eviction_wren_a && line_a == grant_line) begin
            resp_data = evictable_cacheline_a;
        end else if (eviction_wren_b && line_b == grant_line) begin
            resp_data = evictable_cacheline_b;
        end else begin
            resp_data = mem[grant_line];
        end
    end

    assign cacheline_update_valid_a = (state_q == StResp) && !grant_q;
    assign cacheline_update_valid_b = (state_q == StResp) && grant_q;
    assign updated_cacheline_a      = cacheline_update_valid_a ? resp_data : 128'd0;
    assign updated_cacheline_b      = cacheline_update_valid_b ? resp_data : 128'd0;

`ifdef NEXUS_STATS_EN
    logic [16:0] ev_sum;
    assign ev_sum = {1'b0, stat_evictions} + 17'(eviction_wren_a) + 17'(eviction_wren_b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_reads     <= 16'd0;
            stat_evictions <= 16'd0;
        end else begin
            if (resp_done && stat_reads != 16'hFFFF) stat_reads <= stat_reads + 16'd1;
            stat_evictions <= ev_sum[16] ? 16'hFFFF : ev_sum[15:0];
        end
    end
`endif

endmodule

// File: doc/snoop_mem_nexus.md
SNOOP_MEM_NEXUS -- requirements
Module: snoop_mem_nexus

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning backing-store wait cycles per read (legal 1..15).
REQ-002 SHALL have parameter LINE_BITS, default 10, meaning line-index width; the array holds 2^LINE_BITS 128-bit lines.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports snooper_addr_a/_b  input  32  line address from L1a/L1b; bits [3:0] are ignored.
REQ-006 SHALL have ports snooper_read_valid_a/_b  input  1  single-cycle line read request.
REQ-007 SHALL have ports eviction_wren_a/_b  input  1  single-cycle dirty-line write-back strobe.
REQ-008 SHALL have ports evictable_cacheline_a/_b  input  128  write-back data.
REQ-009 SHALL have ports l1_busy_a/_b  input  1  the corresponding L1's hotlink_interrupt; while high, that L1 drops updates.
REQ-010 SHALL have ports updated_cacheline_a/_b  output  128  returned line.
REQ-011 SHALL have ports cacheline_update_valid_a/_b  output  1  returned line is valid this cycle.

Function
REQ-012 SHALL index the array with addr[LINE_BITS+3:4]; upper address bits alias, with no tag check.
REQ-013 SHALL capture a read request into the per-port pending register (flag + address) at the edge ending the request cycle; a request on a port whose flag is already set is dropped.
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, plus a 1-bit grant register and a 4-bit down-counter.
REQ-015 IDLE: if pending_a, grant a; else if pending_b, grant b; on grant, load the counter with LATENCY and go to WAIT; otherwise stay.
REQ-016 WAIT SHALL last exactly LATENCY cycles (decrement each cycle, exit when the counter reaches 1) and then go to RESP.
REQ-017 RESP SHALL assert cacheline_update_valid for the granted port with updated_cacheline = array[line] read combinationally; the other port's outputs stay 0.
REQ-018 RESP with the granted port's l1_busy high SHALL hold RESP (valid stays asserted, data re-read) until l1_busy is low; then it clears that pending flag and returns to IDLE.
REQ-019 Uncontended latency: request in cycle k -> valid in cycle k+LATENCY+2, for exactly one cycle.
REQ-020 Both ports requesting in the same cycle: a is served first; b is granted in the IDLE cycle after a's RESP.
REQ-021 An eviction_wren SHALL write evictable_cacheline to array[line] at that edge, in any FSM state, with no stall.
REQ-022 Simultaneous evictions to the same line from both ports: port a's data wins; different lines: both are written.
REQ-023 An eviction in the RESP cycle to the granted line SHALL be forwarded onto updated_cacheline in that cycle (write-first); if both ports evict it, a's data is forwarded.
REQ-024 updated_cacheline_x SHALL be 128'd0 whenever cacheline_update_valid_x is 0.
REQ-025 Array contents SHALL be initialised to zero for simulation and are never cleared by reset.

Reset
REQ-026 While reset is low, asynchronously: FSM=IDLE, counter=0, grant=a, pending flags and addresses=0, all outputs 0.
REQ-027 Reset mid-WAIT or mid-RESP SHALL abandon the transaction with no response; array writes already completed persist.

Configuration
REQ-028 With NEXUS_STATS_EN defined, the block SHALL add outputs stat_reads[15:0] and stat_evictions[15:0], both saturating at 16'hFFFF and cleared by reset.
REQ-029 stat_reads SHALL count completed RESP exits; stat_evictions SHALL count eviction strobes, +2 when both ports strobe in the same cycle.
REQ-030 Without NEXUS_STATS_EN, those ports and their counters SHALL be absent; all other behaviour is identical.

Verification
REQ-031 LATENCY=4; eviction_wren_a with addr 0x0000_0100, data 0xAAAA...; then read_valid_a with 0x0000_0100 in cycle 10 -> valid_a in cycle 16 only, data 0xAAAA....
REQ-032 read_valid_a and read_valid_b both in cycle 10 -> valid_a in cycle 16; valid_b in cycle 22; never both valid in the same cycle.
REQ-033 l1_busy_a high for cycles 16-18 of REQ-031 -> valid_a held in cycles 16-19, then low; the FSM is in IDLE in cycle 20.
REQ-034 eviction_wren_b to the granted line with 0x5555... in the RESP cycle -> updated_cacheline_a = 0x5555... in that cycle.
REQ-035 reset pulsed low in cycle 13 of REQ-031 -> no valid ever; outputs 0; a later read of 0x100 still returns 0xAAAA....
REQ-036 With NEXUS_STATS_EN, evict on a and b in the same cycle plus one completed read -> stat_evictions=2, stat_reads=1.
